// File: rtl/bfp_block_quantizer.sv
// Block-floating-point quantizer: collects a float32 vector P lanes per beat,
// then aligns every element to the block's largest exponent as an MW-bit signed mantissa.
module bfp_block_quantizer #(
  parameter int V   = 4,
  parameter int P   = 2,
  parameter int BIT = 32,
  parameter int MW  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [P-1:0][BIT-1:0]      vals_in,
  output logic                       out_valid,
  output logic [7:0]                 shared_exp,
  output logic [V-1:0][MW-1:0]       mant_out,
  output logic                       busy
);

  localparam int NB = V / P;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST = BW'(NB - 1);

  logic [BW-1:0]          beat;
  logic [7:0]             run_max;
  logic [7:0]             beat_max;
  logic [V-1:0][BIT-1:0]  coll_q;
  logic [V-1:0][BIT-1:0]  coll_next;
  logic [V-1:0][BIT-1:0]  snap;
  logic [7:0]             snap_max;
  logic                   pending;
  logic [V-1:0][MW-1:0]   mant_next;

  // Running maximum including the lanes of the beat currently presented.
  always_comb begin
    beat_max = run_max;
    for (int j = 0; j < P; j++) begin
      if (vals_in[j][30:23] > beat_max) beat_max = vals_in[j][30:23];
    end
  end

  always_comb begin
    coll_next = coll_q;
    for (int b = 0; b < NB; b++) begin
      if (beat == BW'(b)) begin
        for (int j = 0; j < P; j++) coll_next[b*P+j] = vals_in[j];
      end
    end
  end

  // Per-element alignment against the snapshotted block maximum.
  for (genvar i = 0; i < V; i++) begin : g_align
    logic [7:0]    e;
    logic [23:0]   sig;
    logic [MW-2:0] top;
    logic [7:0]    sh;
    logic [MW-2:0] mag;
    logic [MW-1:0] mag_ext;

    assign e       = snap[i][30:23];
    assign sig     = (e != 8'd0) ? {1'b1, snap[i][22:0]} : 24'd0;
    assign top     = (MW-1)'(sig >> (25 - MW));
    assign sh      = snap_max - e;
    assign mag     = (sh >= 8'(MW - 1)) ? '0 : (top >> sh);
    assign mag_ext = {1'b0, mag};
    assign mant_next[i] = snap[i][31] ? -mag_ext : mag_ext;
  end

  // Collect and align run concurrently: a new vector may begin on the edge
  // that retires the previous block, so pending set must win over clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat       <= '0;
      run_max    <= '0;
      coll_q     <= '0;
      snap       <= '0;
      snap_max   <= '0;
      pending    <= 1'b0;
      out_valid  <= 1'b0;
      shared_exp <= '0;
      mant_out   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (pending) begin
        shared_exp <= snap_max;
        mant_out   <= mant_next;
        out_valid  <= 1'b1;
        pending    <= 1'b0;
      end
      if (valid_in) begin
        coll_q <= coll_next;
        if (beat == LAST) begin
          snap     <= coll_next;
          snap_max <= beat_max;
          pending  <= 1'b1;
          beat     <= '0;
          run_max  <= '0;
        end else begin
          beat    <= beat + BW'(1);
          run_max <= beat_max;
        end
      end
    end
  end

  assign busy = (beat != '0);

endmodule

// File: tb/tb_bfp_block_quantizer.sv
// Self-checking bench for bfp_block_quantizer: MW=8 and MW=4 instances share stimulus
// and are compared against an arithmetic reference model through a scoreboard.
module tb_bfp_block_quantizer;

  localparam int V  = 4;
  localparam int P  = 2;
  localparam int NB = V / P;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid_in = 1'b0;
  logic [P-1:0][31:0] vals_in = '0;

  logic              out8_valid, out4_valid;
  logic [7:0]        exp8, exp4;
  logic [V-1:0][7:0] mant8;
  logic [V-1:0][3:0] mant4;
  logic              busy8, busy4;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  logic [V-1:0][31:0] expVecQ[$];
  int                 dueQ[$];

  bfp_block_quantizer #(.V(V), .P(P), .BIT(32), .MW(8)) dut8 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .vals_in(vals_in),
    .out_valid(out8_valid), .shared_exp(exp8), .mant_out(mant8), .busy(busy8));

  bfp_block_quantizer #(.V(V), .P(P), .BIT(32), .MW(4)) dut4 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .vals_in(vals_in),
    .out_valid(out4_valid), .shared_exp(exp4), .mant_out(mant4), .busy(busy4));

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: value of each element scaled to 2^(MW-1) units of the block exponent, truncated.
  function automatic void refModel(input logic [V-1:0][31:0] vec, input int mw,
                                   output logic [7:0] eexp, output int m[V]);
    int     big;
    int     e;
    int     sh;
    longint sig;
    longint mag;
    big = 0;
    for (int i = 0; i < V; i++) if (int'(vec[i][30:23]) > big) big = int'(vec[i][30:23]);
    eexp = 8'(big);
    for (int i = 0; i < V; i++) begin
      e   = int'(vec[i][30:23]);
      sig = (e == 0) ? 0 : (longint'(1) << 23) + longint'(vec[i][22:0]);
      sh  = big - e;
      if (sh > 40) mag = 0;
      else mag = sig / (longint'(1) << (25 - mw + sh));
      m[i] = vec[i][31] ? -int'(mag) : int'(mag);
    end
  endfunction

  task automatic applyStimulus(input logic [V-1:0][31:0] vec, input int gap);
    for (int b = 0; b < NB; b++) begin
      @(negedge clk);
      valid_in = 1'b1;
      for (int j = 0; j < P; j++) vals_in[j] = vec[b*P+j];
      if (b == NB - 1) begin
        expVecQ.push_back(vec);
        dueQ.push_back(edge_cnt + 2);
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      valid_in = 1'b0;
      vals_in  = '0;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    reset    = 1'b1;
    valid_in = 1'b0;
    expVecQ.delete();
    dueQ.delete();
    @(negedge clk);
    checkOutput("rst_valid", out8_valid, 0);
    checkOutput("rst_busy", busy8, 0);
    checkOutput("rst_exp", exp8, 0);
    checkOutput("rst_mant8", mant8, 0);
    checkOutput("rst_mant4", mant4, 0);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] randElem();
    int         kind;
    logic [7:0] e;
    kind = $urandom_range(0, 9);
    if (kind == 0) e = 8'd0;
    else if (kind == 1) e = 8'($urandom_range(0, 255));
    else e = 8'(120 + $urandom_range(0, 15));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // Scoreboard: every pulse must match the oldest outstanding block and arrive on time.
  logic [V-1:0][31:0] monVec;
  int                 monDue;
  logic [7:0]         monExp;
  int                 monM[V];
  always @(negedge clk) begin
    if (!reset && (out8_valid || out4_valid)) begin
      checkOutput("valid_pair", out4_valid, out8_valid);
      if (expVecQ.size() == 0) begin
        checkOutput("spurious_valid", 1, 0);
      end else begin
        monVec = expVecQ.pop_front();
        monDue = dueQ.pop_front();
        checkOutput("latency", edge_cnt, monDue);
        refModel(monVec, 8, monExp, monM);
        checkOutput("exp8", exp8, monExp);
        for (int i = 0; i < V; i++) checkOutput("mant8", $signed(mant8[i]), monM[i]);
        refModel(monVec, 4, monExp, monM);
        checkOutput("exp4", exp4, monExp);
        for (int i = 0; i < V; i++) checkOutput("mant4", $signed(mant4[i]), monM[i]);
      end
    end
  end

  logic [V-1:0][31:0] t1, t2, t3, t5, rv;

  initial begin
    t1 = {32'h3F000000, 32'hC0800000, 32'h40000000, 32'h3F800000};
    t2 = '0;
    t3 = {32'h0, 32'h0, 32'h0, 32'h40400000};
    t5 = {32'h00000001, 32'hBF800000, 32'h49800000, 32'h3F800000};

    doReset();

    applyStimulus(t1, 4);
    checkOutput("t1_exp", exp8, 129);
    checkOutput("t1_m0", $signed(mant8[0]), 16);
    checkOutput("t1_m1", $signed(mant8[1]), 32);
    checkOutput("t1_m2", $signed(mant8[2]), -64);
    checkOutput("t1_m3", $signed(mant8[3]), 8);
    checkOutput("t1_w4_m0", $signed(mant4[0]), 1);
    checkOutput("t1_w4_m1", $signed(mant4[1]), 2);
    checkOutput("t1_w4_m2", $signed(mant4[2]), -4);
    checkOutput("t1_w4_m3", $signed(mant4[3]), 0);
    checkOutput("hold_valid", out8_valid, 0);

    applyStimulus(t2, 4);
    checkOutput("t2_exp", exp8, 0);
    checkOutput("t2_mant", mant8, 0);

    applyStimulus(t1, 1);
    applyStimulus(t3, 4);
    checkOutput("t3_exp", exp8, 128);
    checkOutput("t3_m0", $signed(mant8[0]), 96);
    applyStimulus(t1, 0);
    applyStimulus(t3, 4);
    checkOutput("t3b_exp", exp8, 128);

    @(negedge clk);
    valid_in = 1'b1;
    vals_in  = {32'h3F800000, 32'h3F800000};
    @(negedge clk);
    valid_in = 1'b0;
    checkOutput("busy_partial", busy8, 1);
    doReset();
    applyStimulus(t1, 4);

    applyStimulus(t5, 4);
    checkOutput("t5_exp", exp8, 147);
    checkOutput("t5_m0", $signed(mant8[0]), 0);
    checkOutput("t5_m1", $signed(mant8[1]), 64);
    checkOutput("t5_m2", $signed(mant8[2]), 0);
    checkOutput("t5_m3", $signed(mant8[3]), 0);

    applyStimulus(t1, 0);
    doReset();
    repeat (4) @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < V; i++) rv[i] = randElem();
      applyStimulus(rv, $urandom_range(0, 2));
    end
    @(negedge clk);
    valid_in = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("drain", expVecQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
